// File: rtl/multiword_add_ctrl_pkg.sv
// Shared types and helpers for the multi-word add/subtract sequencer.
package multiword_add_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Word counter width; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multiword_add_ctrl_adder.sv
// Single-word ripple adder with carry in/out, shared across all words.
module multiword_add_ctrl_adder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout
);

    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b} + {{DATA_WIDTH{1'b0}}, cin};
    end

endmodule

// File: rtl/multiword_add_ctrl.sv
// Sequences one word-wide adder over NUM_WORDS cycles for wide add/sub,
// with a registered, backpressured result stream and final flag report.
module multiword_add_ctrl
    import multiword_add_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_WORDS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in0,
    input  logic [DATA_WIDTH-1:0] in1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_sum,
    output logic                  out_last,
    output logic                  cout,
    output logic                  overflow,
    output logic                  done
);

    localparam int             CW   = cnt_width(NUM_WORDS);
    localparam logic [CW-1:0]  LAST = CW'(NUM_WORDS - 1);
    localparam int             MSB  = DATA_WIDTH - 1;

    state_t                state, state_nx;
    logic                  sub_r;
    logic                  carry_r;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] b_eff;
    logic [DATA_WIDTH-1:0] add_sum;
    logic                  add_cout;
    logic                  accept;
    logic                  is_last;
    logic                  out_fire;
    logic                  carry_msb;

    // Subtraction is A + ~B + 1; the +1 comes from carry_r preloaded with sub.
    assign b_eff     = sub_r ? ~in1 : in1;
    assign is_last   = (cnt == LAST);
    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign busy      = (state != IDLE);
    assign carry_msb = in0[MSB] ^ b_eff[MSB] ^ add_sum[MSB];

    multiword_add_ctrl_adder #(.DATA_WIDTH(DATA_WIDTH)) u_adder (
        .a    (in0),
        .b    (b_eff),
        .cin  (carry_r),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (accept && is_last) state_nx = FLUSH;
            FLUSH:   if (out_fire && out_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sub_r     <= 1'b0;
            carry_r   <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= 1'b0;

            if (state == IDLE && start) begin
                sub_r    <= sub;
                carry_r  <= sub;
                cnt      <= '0;
                cout     <= 1'b0;
                overflow <= 1'b0;
            end

            // A new accept always refills the register, even when the old
            // word is leaving in the same cycle.
            if (accept) begin
                out_sum   <= add_sum;
                out_valid <= 1'b1;
                out_last  <= is_last;
                carry_r   <= add_cout;
                cnt       <= cnt + 1'b1;
                if (is_last) begin
                    cout     <= add_cout;
                    overflow <= carry_msb ^ add_cout;
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end

            if (state == FLUSH && out_fire && out_last)
                done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Scoreboard bench for multiword_add_ctrl with 4 x 8-bit words.
module tb_multiword_add_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, sub, busy;
    logic       in_valid, in_ready;
    logic [7:0] in0, in1;
    logic       out_valid, out_ready, out_last;
    logic [7:0] out_sum;
    logic       cout, overflow, done;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q[$];
    logic       exp_cout, exp_ovf;
    logic       pend = 1'b0;

    multiword_add_ctrl #(.DATA_WIDTH(8), .NUM_WORDS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in0(in0), .in1(in1),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_last(out_last), .cout(cout), .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pops on handshake, done must follow the last word.
    always @(negedge clk) begin
        if (!rst) begin
            logic [8:0] e;
            if (pend || done) begin
                chk("done", {31'd0, done}, {31'd0, pend});
                if (done) begin
                    chk("cout", {31'd0, cout}, {31'd0, exp_cout});
                    chk("ovf", {31'd0, overflow}, {31'd0, exp_ovf});
                end
                pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", {24'd0, out_sum}, {24'd0, e[7:0]});
                    chk("last", {31'd0, out_last}, {31'd0, e[8]});
                    if (e[8]) pend = 1'b1;
                end
            end
        end
    end

    task automatic wait_in_ready();
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic s);
        start = 1'b1;
        sub   = s;
        @(posedge clk); #1;
        start = 1'b0;
        sub   = 1'b0;
    endtask

    // mode 0: plain, 1: stall out_ready after word 0, 2: start pulse during FLUSH
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int mode);
        logic [32:0] r;
        r = s ? ({1'b0, a} + {1'b0, ~b} + 33'd1) : ({1'b0, a} + {1'b0, b});
        exp_cout = r[32];
        exp_ovf  = s ? ((a[31] != b[31]) && (r[31] != a[31]))
                     : ((a[31] == b[31]) && (r[31] != a[31]));
        for (int w = 0; w < 4; w++) exp_q.push_back({(w == 3), r[8*w +: 8]});
        pulse_start(s);
        for (int w = 0; w < 4; w++) begin
            in0 = a[8*w +: 8];
            in1 = b[8*w +: 8];
            in_valid = 1'b1;
            wait_in_ready();
            @(posedge clk); #1;
            if (mode == 1 && w == 0) begin
                in0 = a[15:8];
                in1 = b[15:8];
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("stall_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall_sum", {24'd0, out_sum}, {24'd0, r[7:0]});
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (mode == 2) begin
            out_ready = 1'b0;
            @(posedge clk); #1;
            pulse_start(1'b0);
            @(negedge clk);
            chk("flush_busy", {31'd0, busy}, 32'd1);
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
        wait_idle();
        chk("queue_empty", exp_q.size(), 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0;
        in_valid = 1'b0; in0 = '0; in1 = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", {24'd0, busy, in_ready, out_valid, out_last, cout, overflow, done, 1'b0},
            32'd0);
        chk("rst_sum", {24'd0, out_sum}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(32'h000000FF, 32'h00000001, 1'b0, 0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
        run_op(32'h00000000, 32'h00000001, 1'b1, 0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
        run_op(32'h80000000, 32'h00000001, 1'b1, 0);
        run_op(32'h000000FF, 32'h00000001, 1'b0, 1);
        run_op(32'h12345678, 32'h0FEDCBA9, 1'b1, 2);

        // Reset in the middle of an operation: only word 0 is seen before reset.
        exp_q.push_back({1'b0, 8'h14});
        pulse_start(1'b0);
        for (int w = 0; w < 2; w++) begin
            in0 = (w == 0) ? 8'h04 : 8'h03;
            in1 = 8'h10;
            in_valid = 1'b1;
            wait_in_ready();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++)
            run_op({$urandom}, {$urandom}, i[0], 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
